// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Holds the state encoding, the power-on init command list and io_lcd bit positions.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_WAIT
  } lcd_state_e;

  localparam int INIT_LEN = 6;

  // Entry 0 is sent first: 8-bit/2-line function set three times, display on,
  // clear, entry mode increment.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
  };

  localparam int BIT_ON  = 31;
  localparam int BIT_TOG = 30;
  localparam int BIT_RS  = 9;

  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;

  // Clear and home are the only instructions needing the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == OP_CLEAR) || (data == OP_HOME));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed state of the LCD controller.
// done is high while the count sits at zero; a load of N-1 yields N cycles.
module lcd_delay_cnt
  import lcd_pkg::*;
#(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= RESET_VAL;
    end else if (load) begin
      cnt_reg <= value;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 controller: autonomous power-on init, then one timed RS/DATA/EN write
// per toggle of the request bit in the io_lcd register, with a pollable busy flag.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = 750_000,
  parameter int T_EN_CYC    = 25,
  parameter int T_CMD_CYC   = 2_500,
  parameter int T_CLR_CYC   = 100_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] io_lcd_i,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o,
  output logic [31:0] lcd_status_o
);

  localparam int T_MAX = max_int(max_int(T_PWRUP_CYC, T_EN_CYC), max_int(T_CMD_CYC, T_CLR_CYC));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(T_PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(T_CMD_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(T_CLR_CYC - 1);

  lcd_state_e       state_reg;
  logic [2:0]       idx_reg;
  logic             init_done_reg;
  logic             last_tog_reg;
  logic             on_reg;
  logic             en_reg;
  logic             rs_reg;
  logic [7:0]       data_reg;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_done;
  logic [CNT_W-1:0] wait_load;
  logic             req_pending;
  logic             unused_io_bits;

  assign req_pending    = (io_lcd_i[BIT_TOG] != last_tog_reg);
  assign wait_load      = is_long_cmd(rs_reg, data_reg) ? CLR_LOAD : CMD_LOAD;
  assign unused_io_bits = ^{io_lcd_i[29:10], io_lcd_i[8]};

  // The counter comes out of reset already holding the power-up wait, so
  // only the EN pulse and the post-EN wait need explicit loads.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state_reg)
      ST_SETUP: begin
        cnt_load  = 1'b1;
        cnt_value = EN_LOAD;
      end
      ST_EN_HI: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          cnt_value = wait_load;
        end
      end
      default: ;
    endcase
  end

  lcd_delay_cnt #(
    .W         (CNT_W),
    .RESET_VAL (PWRUP_LOAD)
  ) u_delay_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load   (cnt_load),
    .value  (cnt_value),
    .done   (cnt_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_PWRUP;
      idx_reg       <= '0;
      init_done_reg <= 1'b0;
      last_tog_reg  <= 1'b0;
      on_reg        <= 1'b0;
      en_reg        <= 1'b0;
      rs_reg        <= 1'b0;
      data_reg      <= '0;
    end else begin
      on_reg <= io_lcd_i[BIT_ON];
      case (state_reg)
        ST_PWRUP: begin
          if (cnt_done) begin
            idx_reg   <= '0;
            state_reg <= ST_INIT;
          end
        end
        ST_INIT: begin
          rs_reg    <= 1'b0;
          data_reg  <= INIT_ROM[idx_reg];
          state_reg <= ST_SETUP;
        end
        ST_IDLE: begin
          // Whatever sits in io_lcd now is what gets sent; older values are lost.
          if (req_pending) begin
            rs_reg       <= io_lcd_i[BIT_RS];
            data_reg     <= io_lcd_i[7:0];
            last_tog_reg <= io_lcd_i[BIT_TOG];
            state_reg    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          en_reg    <= 1'b1;
          state_reg <= ST_EN_HI;
        end
        ST_EN_HI: begin
          if (cnt_done) begin
            en_reg    <= 1'b0;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_done) begin
            if (!init_done_reg) begin
              if (idx_reg == 3'(INIT_LEN - 1)) begin
                init_done_reg <= 1'b1;
                state_reg     <= ST_IDLE;
              end else begin
                idx_reg   <= idx_reg + 1'b1;
                state_reg <= ST_INIT;
              end
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_PWRUP;
      endcase
    end
  end

  assign lcd_on_o     = on_reg;
  assign lcd_en_o     = en_reg;
  assign lcd_rs_o     = rs_reg;
  assign lcd_rw_o     = 1'b0;
  assign lcd_data_o   = data_reg;
  assign lcd_status_o = {30'b0, init_done_reg, (state_reg != ST_IDLE)};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: expected LCD transactions are queued as
// stimulus is applied and compared when EN pulses appear on the pins.
module tb_lcd_ctrl;

  localparam int T_PWRUP = 10;
  localparam int T_EN    = 2;
  localparam int T_CMD   = 4;
  localparam int T_CLR   = 8;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         low_len;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic        on_bit;
  logic [30:0] req_word;
  logic [31:0] io_lcd;
  logic        lcd_on;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic [31:0] lcd_status;

  int   checks_cnt;
  int   fail_cnt;
  txn_t exp_q[$];
  logic on_exp;
  logic [7:0] init_vals [6];

  assign io_lcd = {on_bit, req_word};

  lcd_ctrl #(
    .T_PWRUP_CYC (T_PWRUP),
    .T_EN_CYC    (T_EN),
    .T_CMD_CYC   (T_CMD),
    .T_CLR_CYC   (T_CLR)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .io_lcd_i     (io_lcd),
    .lcd_on_o     (lcd_on),
    .lcd_en_o     (lcd_en),
    .lcd_rs_o     (lcd_rs),
    .lcd_rw_o     (lcd_rw),
    .lcd_data_o   (lcd_data),
    .lcd_status_o (lcd_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] data);
    return (!rs && (data == 8'h01 || data == 8'h02)) ? T_CLR : T_CMD;
  endfunction

  // Power rail request is a plain one-cycle register of bit 31.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) on_exp <= 1'b0;
    else        on_exp <= io_lcd[31];
  end

  initial forever begin
    @(negedge clk);
    if ($urandom_range(3) == 0) on_bit = ~on_bit;
  end

  // Pin monitor: pops one expected transaction per EN rise.
  initial begin : monitor
    txn_t cur;
    logic en_prev;
    int   high_cnt;
    int   low_cnt;
    bit   counting;
    en_prev  = 1'b0;
    high_cnt = 0;
    low_cnt  = 0;
    counting = 1'b0;
    cur      = '{1'b0, 8'h00, 0};
    forever begin
      @(negedge clk);
      check("lcd_on", {31'b0, lcd_on}, {31'b0, on_exp});
      if (!rst_n) begin
        en_prev  = 1'b0;
        counting = 1'b0;
      end else begin
        if (lcd_en && !en_prev) begin
          if (counting) begin
            check("gap_len", low_cnt, cur.low_len);
            counting = 1'b0;
          end
          check("en_expected", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("rs", {31'b0, lcd_rs}, {31'b0, cur.rs});
            check("data", {24'b0, lcd_data}, {24'b0, cur.data});
            $display("txn rs=%0d data=0x%02h t=%0t", lcd_rs, lcd_data, $time);
          end
          high_cnt = 1;
        end else if (lcd_en) begin
          high_cnt++;
        end else if (en_prev) begin
          check("en_len", high_cnt, T_EN);
          check("data_hold", {23'b0, lcd_rs, lcd_data}, {23'b0, cur.rs, cur.data});
          low_cnt  = 1;
          counting = 1'b1;
        end else if (counting) begin
          if (lcd_status[0]) begin
            low_cnt++;
          end else begin
            check("wait_len", low_cnt, cur.low_len);
            counting = 1'b0;
          end
        end
        en_prev = lcd_en;
      end
    end
  end

  task automatic push_init();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{1'b0, init_vals[i],
                        wait_of(1'b0, init_vals[i]) + ((i == 5) ? 0 : 2)});
    end
  endtask

  task automatic wait_status(input logic [31:0] exp, input int bound);
    int n;
    n = 0;
    while (lcd_status !== exp && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("status_reach", lcd_status, exp);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("queue_drain", exp_q.size(), 0);
  endtask

  // Called with rst_n low; releases it and checks the power-up window.
  task automatic release_and_init(input bit hold);
    push_init();
    if (hold) exp_q.push_back('{1'b1, 8'h48, T_CMD});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < T_PWRUP; i++) begin
      @(negedge clk);
      check("pwrup_status", lcd_status, 32'h1);
      check("pwrup_pins", {22'b0, lcd_en, lcd_rs, lcd_data}, 32'h0);
      if (hold && i == 3) req_word = 31'h4000_0248;
    end
    wait_drain(400);
    wait_status(32'h2, 100);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_req(input logic [30:0] word, input int exp_busy);
    int busy_cnt;
    logic [7:0] d;
    d = word[7:0];
    exp_q.push_back('{word[9], d, wait_of(word[9], d)});
    req_word = word;
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) check("accept_busy", {31'b0, lcd_status[0]}, 32'd1);
      if (!lcd_status[0]) break;
      busy_cnt++;
    end
    check("busy_len", busy_cnt, exp_busy);
    check("status_idle", lcd_status, 32'h2);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    init_vals  = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    checks_cnt = 0;
    fail_cnt   = 0;
    rst_n      = 1'b0;
    on_bit     = 1'b0;
    req_word   = '0;
    repeat (3) @(negedge clk);
    check("reset_status", lcd_status, 32'h1);
    check("reset_pins", {21'b0, lcd_rw, lcd_en, lcd_rs, lcd_data}, 32'h0);

    // Plain init, then a data write and a clear.
    release_and_init(1'b0);
    check("rw_low", {31'b0, lcd_rw}, 32'd0);
    send_req(31'h4000_0241, 1 + T_EN + T_CMD);
    send_req(31'h0000_0001, 1 + T_EN + T_CLR);

    // Request toggled during power-up is held until init completes.
    @(negedge clk);
    rst_n    = 1'b0;
    req_word = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    release_and_init(1'b1);

    // Reset while EN is high must drop the pins at once and restart init.
    exp_q.push_back('{1'b1, 8'h55, T_CMD});
    req_word = 31'h0000_0255;
    for (int i = 0; i < 20 && !lcd_en; i++) @(negedge clk);
    check("en_seen", {31'b0, lcd_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_pins", {22'b0, lcd_en, lcd_rs, lcd_data}, 32'h0);
    check("async_status", lcd_status, 32'h1);
    repeat (2) @(negedge clk);
    release_and_init(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
